// File: rtl/wrr_next_grant.sv
// wrr_next_grant: weighted round-robin next-grant calculator.
//
// The current owner keeps the grant for up to weight[owner] acknowledged
// transfers (its credit). Once the credit is used up, or the owner stops
// requesting, priority moves to the first requester after the owner,
// wrapping around. The owner itself is considered last. All outputs are
// registered.
//
// Ports:
//   clk_i               system clock, rising edge
//   reset_i             asynchronous, active-high reset
//   request_i           per-channel level-sensitive request
//   weight_i            per-channel credit count, channel i at [i*WEIGHT_W +: WEIGHT_W]
//   grant_ack_i         one transfer of the presented grant was consumed
//   next_grant_o        one-hot next grant, or all zeros
//   next_grant_valid_o  next_grant_o is nonzero
//   grant_idx_o         binary index of next_grant_o, 0 when invalid
module wrr_next_grant #(
    parameter int unsigned CHANNELS = 8,
    parameter int unsigned WEIGHT_W = 4,
    parameter int unsigned IDX_W    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                         clk_i,
    input  logic                         reset_i,
    input  logic [CHANNELS-1:0]          request_i,
    input  logic [CHANNELS*WEIGHT_W-1:0] weight_i,
    input  logic                         grant_ack_i,
    output logic [CHANNELS-1:0]          next_grant_o,
    output logic                         next_grant_valid_o,
    output logic [IDX_W-1:0]             grant_idx_o
);

    typedef enum logic [1:0] {
        StInit = 2'b00,
        StRun  = 2'b01
    } state_e;

    state_e              state_q, state_d;
    logic [CHANNELS-1:0] owner_q, owner_d;
    logic [WEIGHT_W-1:0] credit_q, credit_d;
    logic [CHANNELS-1:0] grant_d;
    logic [IDX_W-1:0]    idx_d;

    logic [IDX_W-1:0]    owner_idx;
    logic                scan_found;
    logic [IDX_W-1:0]    scan_idx;
    logic [CHANNELS-1:0] scan_grant;
    logic [WEIGHT_W-1:0] scan_weight;
    logic [WEIGHT_W-1:0] load_credit;
    logic [WEIGHT_W-1:0] credit_rem;
    logic                hold;

    function automatic logic [IDX_W-1:0] wrap_idx(input int unsigned v);
        return IDX_W'(v % CHANNELS);
    endfunction

    // Binary index of the one-hot owner.
    always_comb begin
        owner_idx = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (owner_q[i]) begin
                owner_idx = IDX_W'(i);
            end
        end
    end

    // Scan from owner+1 upward, wrapping; the owner is the last candidate.
    always_comb begin
        scan_found = 1'b0;
        scan_idx   = '0;
        for (int unsigned k = 1; k <= CHANNELS; k++) begin
            if (!scan_found && request_i[wrap_idx(32'(owner_idx) + k)]) begin
                scan_found = 1'b1;
                scan_idx   = wrap_idx(32'(owner_idx) + k);
            end
        end
    end

    assign scan_grant  = scan_found ? (CHANNELS'(1) << scan_idx) : '0;
    assign scan_weight = weight_i[32'(scan_idx)*WEIGHT_W +: WEIGHT_W];
    // A zero weight still grants one transfer.
    assign load_credit = (scan_weight == '0) ? WEIGHT_W'(1) : scan_weight;

    // The ack only counts against a grant that is actually presented.
    assign credit_rem = (grant_ack_i && next_grant_valid_o && (credit_q != '0))
                      ? credit_q - WEIGHT_W'(1) : credit_q;
    assign hold       = ((request_i & owner_q) != '0) && (credit_rem != '0);

    always_comb begin
        state_d  = state_q;
        owner_d  = owner_q;
        credit_d = credit_q;
        grant_d  = '0;
        idx_d    = '0;
        case (state_q)
            StInit: begin
                // Owner at the top channel so channel 0 is scanned first.
                owner_d  = CHANNELS'(1) << (CHANNELS - 1);
                credit_d = '0;
                state_d  = StRun;
            end
            StRun: begin
                if (hold) begin
                    grant_d  = owner_q;
                    idx_d    = owner_idx;
                    credit_d = credit_rem;
                end else if (scan_found) begin
                    grant_d  = scan_grant;
                    idx_d    = scan_idx;
                    owner_d  = scan_grant;
                    credit_d = load_credit;
                end else begin
                    // Idle: keep the pointer, but an ack of the grant that was
                    // on the outputs still consumes its credit.
                    credit_d = credit_rem;
                end
            end
            default: begin
                state_d  = StInit;
                owner_d  = '0;
                credit_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q            <= StInit;
            owner_q            <= '0;
            credit_q           <= '0;
            next_grant_o       <= '0;
            next_grant_valid_o <= 1'b0;
            grant_idx_o        <= '0;
        end else begin
            state_q            <= state_d;
            owner_q            <= owner_d;
            credit_q           <= credit_d;
            next_grant_o       <= grant_d;
            next_grant_valid_o <= |grant_d;
            grant_idx_o        <= idx_d;
        end
    end

endmodule

// File: tb/tb_wrr_next_grant.sv
// Testbench for wrr_next_grant (8 channels, 4-bit weights).
// Stimulus pushes the expected registered output for each cycle it drives;
// a monitor pops and compares shortly after every rising edge.
module tb_wrr_next_grant;

    localparam int CH = 8;
    localparam int WW = 4;
    localparam int IW = 3;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [CH-1:0] request = 8'hFF;
    logic [CH*WW-1:0] weight = {8{4'h1}};
    logic          ack = 1'b0;
    logic [CH-1:0] next_grant;
    logic          next_grant_valid;
    logic [IW-1:0] grant_idx;

    int checks = 0;
    int passes = 0;

    logic [7:0] exp_q[$];
    string      name_q[$];
    logic [7:0] mon_g;
    string      mon_n;

    wrr_next_grant #(
        .CHANNELS (CH),
        .WEIGHT_W (WW),
        .IDX_W    (IW)
    ) dut (
        .clk_i              (clk),
        .reset_i            (reset),
        .request_i          (request),
        .weight_i           (weight),
        .grant_ack_i        (ack),
        .next_grant_o       (next_grant),
        .next_grant_valid_o (next_grant_valid),
        .grant_idx_o        (grant_idx)
    );

    always #5 clk = ~clk;

    function automatic logic [IW-1:0] idx_of(input logic [7:0] g);
        logic [IW-1:0] r;
        r = '0;
        for (int i = 0; i < CH; i++) begin
            if (g[i]) r = IW'(i);
        end
        return r;
    endfunction

    task automatic compare(input string nm, input logic [7:0] eg);
        checks++;
        if (next_grant === eg && next_grant_valid === (|eg) && grant_idx === idx_of(eg)) begin
            passes++;
        end else begin
            $display("FAIL %s: got grant=%h valid=%b idx=%0d, expected grant=%h valid=%b idx=%0d",
                     nm, next_grant, next_grant_valid, grant_idx, eg, |eg, idx_of(eg));
        end
    endtask

    // Called at a falling edge: drive inputs, queue the output expected
    // after the coming rising edge, and advance to the next falling edge.
    task automatic step(input logic [7:0] req, input logic a, input logic [7:0] eg,
                        input string nm);
        request = req;
        ack     = a;
        exp_q.push_back(eg);
        name_q.push_back(nm);
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        forever begin
            @(posedge clk);
            #2;
            if (exp_q.size() != 0) begin
                mon_g = exp_q.pop_front();
                mon_n = name_q.pop_front();
                compare(mon_n, mon_g);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

    logic [7:0] wseq[8] = '{8'h01, 8'h01, 8'h01, 8'h02, 8'h01, 8'h01, 8'h01, 8'h02};
    logic [7:0] zseq[4] = '{8'h01, 8'h02, 8'h01, 8'h02};

    initial begin
        // Reset with all channels requesting.
        @(negedge clk);
        @(negedge clk);
        compare("reset_idle", 8'h00);
        reset = 1'b0;
        step(8'hFF, 1'b1, 8'h00, "init_cycle");
        step(8'hFF, 1'b1, 8'h01, "first_grant");

        // Equal weights, ack held high.
        for (int i = 1; i < CH; i++) step(8'hFF, 1'b1, 8'(1 << i), "equal_rr");
        step(8'hFF, 1'b1, 8'h01, "equal_rr_wrap");

        // Weighted hold: ch0=3, ch1=1.
        weight = {8{4'h1}};
        weight[3:0] = 4'd3;
        do_reset();
        step(8'h03, 1'b1, 8'h00, "w_init");
        for (int i = 0; i < 8; i++) step(8'h03, 1'b1, wseq[i], "weighted_hold");
        // ch0 weight 0 behaves as 1.
        weight[3:0] = 4'd0;
        for (int i = 0; i < 4; i++) step(8'h03, 1'b1, zseq[i], "zero_weight");

        // Wrap-around and sparse requests.
        weight = {8{4'h1}};
        do_reset();
        step(8'h40, 1'b0, 8'h00, "wrap_init");
        step(8'h40, 1'b0, 8'h40, "wrap_own6");
        step(8'h40, 1'b0, 8'h40, "wrap_hold6");
        step(8'h41, 1'b1, 8'h01, "wrap_to_ch0");
        step(8'h00, 1'b1, 8'h00, "idle_none");
        step(8'h41, 1'b1, 8'h40, "pointer_kept");

        // Release without ack.
        weight = {8{4'h1}};
        weight[11:8] = 4'd5;
        do_reset();
        step(8'h04, 1'b0, 8'h00, "rel_init");
        step(8'h04, 1'b0, 8'h04, "rel_own2");
        for (int i = 0; i < 20; i++) step(8'h24, 1'b0, 8'h04, "hold_no_ack");
        step(8'h20, 1'b0, 8'h20, "release_drop");

        // Reset in the middle of a hold.
        weight = {8{4'h1}};
        weight[15:12] = 4'd4;
        do_reset();
        step(8'h08, 1'b0, 8'h00, "mr_init");
        step(8'h08, 1'b1, 8'h08, "mr_load4");
        step(8'h08, 1'b1, 8'h08, "mr_credit3");
        step(8'h08, 1'b1, 8'h08, "mr_credit2");
        ack = 1'b0;
        weight[15:12] = 4'd3;
        #2 reset = 1'b1;
        #1 compare("async_reset", 8'h00);
        @(negedge clk);
        reset = 1'b0;
        step(8'h08, 1'b1, 8'h00, "mr_init2");
        step(8'h18, 1'b1, 8'h08, "mr_reload");
        step(8'h18, 1'b1, 8'h08, "mr_reload_c2");
        step(8'h18, 1'b1, 8'h08, "mr_reload_c1");
        step(8'h18, 1'b1, 8'h10, "mr_rotate");

        for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(negedge clk);
        if (exp_q.size() != 0) begin
            checks++;
            $display("FAIL drain: got %0d pending expectations, expected 0", exp_q.size());
        end
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/wrr_next_grant.md
Name: wrr_next_grant

Overview:
- Parametrised weighted round-robin next-grant calculator. It is the successor to the fixed single-cycle rotate-mask precalculator.
- Each requestor holds the grant for up to a programmable number of acknowledged transfers (credits) before priority rotates. Priority rotates to the next requester after the current owner, cyclically.
- Sits between the request aggregation logic and the grant register of the arbiter. Outputs are registered.

Parameters:
- CHANNELS, 8, number of requestors; legal range 1 and up.
- WEIGHT_W, 4, width of each per-channel weight and of the credit counter.
- IDX_W, $clog2(CHANNELS) (1 when CHANNELS=1), width of grant_idx.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high system reset.
- request  input  CHANNELS  per-channel request, level-sensitive.
- weight  input  CHANNELS*WEIGHT_W  per-channel credit count; channel i uses bits [i*WEIGHT_W +: WEIGHT_W]. Sampled only on credit load.
- grant_ack  input  1  current grant consumed one transfer; ignored when next_grant_valid=0.
- next_grant  output  CHANNELS  one-hot next grant, or all zeros.
- next_grant_valid  output  1  high when next_grant is nonzero.
- grant_idx  output  IDX_W  binary index of next_grant; 0 when invalid.

Behaviour:
- Reset, asynchronous and immediate, including mid-operation:
  - next_grant=0, next_grant_valid=0, grant_idx=0.
  - Internal owner (one-hot) = 0, credit=0, state=INIT.
- State machine, 2-bit with states INIT and RUN:
  - INIT: one cycle after reset deasserts. Sets owner = bit CHANNELS-1, so channel 0 wins first. Sets credit=0. Outputs stay 0. Transitions to RUN unconditionally.
  - RUN: stays in RUN until reset.
  - Illegal state encoding: go to INIT and drive outputs 0.
- RUN, per cycle, combinational decision:
  - credit_rem = credit - 1 if (grant_ack and next_grant_valid and credit != 0); otherwise credit_rem = credit.
  - hold = (request & owner) != 0 and credit_rem != 0.
  - If hold: next = owner; credit <= credit_rem; owner unchanged.
  - Else: next = the first set request bit scanning from owner_index+1 upward, wrapping modulo CHANNELS. The owner itself is checked last. This covers wrap-around: owner ch6 with request=8'h41 gives ch0.
  - Else-branch with next != 0: owner <= next; credit <= weight[next]. A weight of 0 is treated as 1. The load happens even if next equals the old owner, i.e. re-selection after exhaustion.
  - Else-branch with request == 0: next = 0; owner and credit unchanged, so the priority pointer is preserved.
- Registered outputs, each updated every RUN cycle:
  - next_grant <= next.
  - next_grant_valid <= |next.
  - grant_idx <= index(next).
- Latency:
  - request change to outputs: 1 clk.
  - grant_ack on exhausting the last credit to a new next_grant: 1 clk.
- Request drop by the owner releases the grant immediately, with no ack needed. Remaining credit is discarded.
- No ack: the grant holds indefinitely while the owner keeps requesting.
- Simultaneous ack and owner request drop: treated as a release; the new owner gets a fresh credit load.
- Ack with credit already 0 cannot occur in RUN with a valid grant; it is guarded anyway, with no underflow.
- CHANNELS=1: next_grant = request[0]; credit reloads on exhaustion; grant_idx fixed at 0.
- Weight changes take effect only at the next credit load of that channel.

Test Plan:
- Reset then idle:
  - Assert reset with request=8'hFF → all outputs 0 asynchronously.
  - Deassert reset → INIT cycle, outputs still 0.
  - Next edge → next_grant=8'h01, grant_idx=0.
- Equal weights:
  - All weights=1, request=8'hFF, grant_ack held high → next_grant sequence 01,02,04,08,10,20,40,80,01.
- Weighted hold:
  - weight ch0=3, ch1=1, request=8'h03, ack every cycle → 01,01,01,02,01,01,01,02.
  - weight ch0=0 acts as 1 → 01,02,01,02.
- Wrap and sparse:
  - Owner ch6 exhausts its credit, request=8'h41 → next_grant=8'h01, grant_idx=0.
  - Then request=8'h00 → next_grant=0, valid=0.
  - Then request=8'h41 again → 8'h40, confirming the pointer was preserved.
- Release without ack:
  - Owner ch2 with weight=5, no ack; drop request[2] while request=8'h24 → next_grant=8'h20 after 1 clk.
  - With no ack and request held → grant stays 8'h04 for 20 cycles.
- Reset mid-hold:
  - Owner ch3 with 2 credits left; pulse reset → outputs 0 immediately.
  - After the INIT cycle with request=8'h08 → next_grant=8'h08 and credit reloaded from weight[3].
